parking_gate_controller: RTL

- Entrance-gate controller for the car park.
- Consumes the divided clk_1Hz produced by the clock-divider stage as a seconds time base.
- Runs the password/gate state machine on the system clock and tracks occupancy.
- Drives the gate actuator, LEDs, alarm and a seconds countdown for the display stage.

---
 rtl/parking_gate_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_controller.sv
// Entrance-gate controller: password/gate state machine on clk_50MHz, seconds
// countdown from the synchronized clk_1Hz, and car-park occupancy tracking.
module parking_gate_controller #(
    parameter logic [1:0]  PASS1        = 2'b01,
    parameter logic [1:0]  PASS2        = 2'b10,
    parameter int unsigned WAIT_SECS    = 5,
    parameter int unsigned OPEN_SECS    = 3,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned LOCKOUT_SECS = 10,
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned TIMER_W      = 4,
    parameter int unsigned COUNT_W      = 4
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               clk_1Hz,
    input  logic               sensor_entrance,
    input  logic               sensor_exit,
    input  logic               submit,
    input  logic [1:0]         password_1,
    input  logic [1:0]         password_2,
    output logic               gate_open,
    output logic               green_led,
    output logic               red_led,
    output logic               alarm,
    output logic               full,
    output logic [2:0]         state_code,
    output logic [TIMER_W-1:0] seconds_left,
    output logic [COUNT_W-1:0] car_count
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        LOCKOUT       = 3'd4
    } state_e;

    // [0],[1] are the synchronizer pair, [2] holds the previous synced value
    logic [2:0]         clk1_sh;
    logic [2:0]         exit_sh;
    logic [2:0]         sub_sh;
    logic [1:0]         ent_sh;
    logic               sec_tick;
    logic               exit_evt;
    logic               submit_evt;
    logic               ent_level;
    logic               blink;

    state_e             state;
    state_e             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [TRIES_W-1:0] tries;
    logic [TRIES_W-1:0] tries_nxt;
    logic [TRIES_W-1:0] tries_inc;
    logic [COUNT_W-1:0] count_nxt;
    logic               car_inc;
    logic               expire;
    logic               pass_ok;
    logic               gate_nxt;
    logic               green_nxt;
    logic               red_nxt;
    logic               alarm_nxt;

    assign ent_level    = ent_sh[1];
    assign blink        = clk1_sh[1];
    assign expire       = sec_tick && (timer == TIMER_W'(1));
    assign pass_ok      = (password_1 == PASS1) && (password_2 == PASS2);
    assign tries_inc    = tries + TRIES_W'(1);
    assign full         = (car_count == COUNT_W'(CAPACITY));
    assign state_code   = state;
    assign seconds_left = timer;

    // Input synchronizers; edge pulses are registered so a rise shows 3 cycles later
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            clk1_sh    <= '0;
            exit_sh    <= '0;
            sub_sh     <= '0;
            ent_sh     <= '0;
            sec_tick   <= 1'b0;
            exit_evt   <= 1'b0;
            submit_evt <= 1'b0;
        end else begin
            clk1_sh    <= {clk1_sh[1:0], clk_1Hz};
            exit_sh    <= {exit_sh[1:0], sensor_exit};
            sub_sh     <= {sub_sh[1:0], submit};
            ent_sh     <= {ent_sh[0], sensor_entrance};
            sec_tick   <= clk1_sh[1] & ~clk1_sh[2];
            exit_evt   <= exit_sh[1] & ~exit_sh[2];
            submit_evt <= sub_sh[1] & ~sub_sh[2];
        end
    end

    // State, countdown, attempt counter, occupancy and registered outputs
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            tries     <= '0;
            car_count <= '0;
            gate_open <= 1'b0;
            green_led <= 1'b0;
            red_led   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            tries     <= tries_nxt;
            car_count <= count_nxt;
            gate_open <= gate_nxt;
            green_led <= green_nxt;
            red_led   <= red_nxt;
            alarm     <= alarm_nxt;
        end
    end

    // Next-state logic; a submit in the same cycle as expiry takes priority
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        tries_nxt = tries;
        car_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (ent_level && !full) begin
                    state_nxt = WAIT_PASSWORD;
                    tries_nxt = '0;
                    timer_nxt = TIMER_W'(WAIT_SECS);
                end
            end
            WAIT_PASSWORD, WRONG_PASS: begin
                if (submit_evt) begin
                    if (pass_ok) begin
                        state_nxt = RIGHT_PASS;
                        timer_nxt = TIMER_W'(OPEN_SECS);
                    end else if (tries_inc == TRIES_W'(MAX_TRIES)) begin
                        state_nxt = LOCKOUT;
                        tries_nxt = tries_inc;
                        timer_nxt = TIMER_W'(LOCKOUT_SECS);
                    end else begin
                        state_nxt = WRONG_PASS;
                        tries_nxt = tries_inc;
                        timer_nxt = TIMER_W'(WAIT_SECS);
                    end
                end else if (expire) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (sec_tick) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            RIGHT_PASS: begin
                if (expire) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    car_inc   = 1'b1;
                end else if (sec_tick) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            LOCKOUT: begin
                if (expire) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    tries_nxt = '0;
                end else if (sec_tick) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                tries_nxt = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so LEDs line up with state_code
    always_comb begin
        gate_nxt  = 1'b0;
        green_nxt = 1'b0;
        red_nxt   = 1'b0;
        alarm_nxt = 1'b0;
        count_nxt = car_count;
        case (state_nxt)
            RIGHT_PASS: begin
                gate_nxt  = 1'b1;
                green_nxt = 1'b1;
            end
            WAIT_PASSWORD: red_nxt = 1'b1;
            WRONG_PASS:    red_nxt = blink;
            LOCKOUT: begin
                alarm_nxt = 1'b1;
                red_nxt   = blink;
            end
            default: ;
        endcase
        if (car_inc && !exit_evt && (car_count != COUNT_W'(CAPACITY))) begin
            count_nxt = car_count + COUNT_W'(1);
        end else if (exit_evt && !car_inc && (car_count != '0)) begin
            count_nxt = car_count - COUNT_W'(1);
        end
    end

endmodule
